// File: rtl/rca_seq_pkg.sv
// ----------------------------------------------------------------------------
// rca_seq_pkg
//   Shared definitions for the sliced ripple-carry add/subtract sequencer:
//   FSM state encodings, the default slice width and a helper that derives
//   the full operand width from the slice geometry.
// ----------------------------------------------------------------------------
package rca_seq_pkg;

    // Two-bit state encodings for the sequencer FSM.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Width of the RCA slice; the RCA ports are hard-wired to this value.
    localparam int SLICE_W_DEF = 4;

    // Full operand width built from nslice slices of slice_w bits each.
    function automatic int total_w(input int slice_w, input int nslice);
        return slice_w * nslice;
    endfunction

endpackage

// File: rtl/RCA.sv
// ----------------------------------------------------------------------------
// RCA
//   4-bit combinational ripple-carry adder: {cout, s} = a + b + cin.
//
//   Ports:
//     a    in   4  addend A
//     b    in   4  addend B
//     cin  in   1  carry into bit 0
//     s    out  4  sum
//     cout out  1  carry out of bit 3
// ----------------------------------------------------------------------------
module RCA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    // c[i] is the carry into bit i; c[4] leaves the adder.
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rca_seq_ctrl
//   Multi-cycle add/subtract sequencer around a single 4-bit RCA. A wide
//   operand pair is latched on an accepted start and fed to the RCA one slice
//   per clock, LSB slice first, with the carry registered between slices so
//   the combinational carry chain never exceeds one slice.
//
//   Ports:
//     clk     in   1        rising-edge clock
//     rst_n   in   1        asynchronous active-low reset
//     start   in   1        request, sampled only while idle
//     op_sub  in   1        0: a + b + cin, 1: a - b (cin ignored)
//     a       in   TOTAL_W  operand A, latched on accepted start
//     b       in   TOTAL_W  operand B, latched on accepted start
//     cin     in   1        carry-in for add, latched on accepted start
//     busy    out  1        high while not idle (RUN and DONE)
//     done    out  1        one-cycle completion pulse
//     s       out  TOTAL_W  result, stable from done until next start
//     cout    out  1        final carry (subtract: 1 = no borrow)
// ----------------------------------------------------------------------------
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF,  // must stay 4 to match RCA
    parameter int NSLICE  = 4             // must be >= 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    op_sub,
    input  logic [total_w(SLICE_W, NSLICE)-1:0]     a,
    input  logic [total_w(SLICE_W, NSLICE)-1:0]     b,
    input  logic                                    cin,
    output logic                                    busy,
    output logic                                    done,
    output logic [total_w(SLICE_W, NSLICE)-1:0]     s,
    output logic                                    cout
);

    localparam int TOTAL_W = total_w(SLICE_W, NSLICE);
    localparam int IDX_W   = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t               state_q, state_d;
    logic [TOTAL_W-1:0]   a_q, a_d;
    logic [TOTAL_W-1:0]   b_q, b_d;      // already inverted for subtract
    logic                 carry_q, carry_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TOTAL_W-1:0]   s_q, s_d;
    logic                 cout_q, cout_d;

    logic [SLICE_W-1:0]   rca_a;
    logic [SLICE_W-1:0]   rca_b;
    logic [SLICE_W-1:0]   rca_s;
    logic                 rca_cout;

    // Slice mux: present slice idx_q of the latched operands to the adder.
    always_comb begin
        rca_a = '0;
        rca_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rca_a = a_q[i*SLICE_W +: SLICE_W];
                rca_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    RCA u_rca (
        .a    (rca_a),
        .b    (rca_b),
        .cin  (carry_q),
        .s    (rca_s),
        .cout (rca_cout)
    );

    // Next-state and datapath update.
    // NOTE: every signal is given its hold value first so no path through
    // the case leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    // Subtract is a + ~b + 1: invert B and force the carry.
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        s_d[i*SLICE_W +: SLICE_W] = rca_s;
                    end
                end
                carry_d = rca_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = rca_cout;
                    idx_d   = '0;   // no wrap path; idx restarts here
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rca_seq_ctrl
//   Scoreboard bench for rca_seq_ctrl (NSLICE=4, 16-bit operands). Each issued
//   request pushes its expected {cout,s} and done cycle; a monitor on the
//   falling edge pops and compares whenever done is high.
// ----------------------------------------------------------------------------
module tb_rca_seq_ctrl;

    localparam int NSLICE  = 4;
    localparam int TOTAL_W = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               op_sub;
    logic [TOTAL_W-1:0] a;
    logic [TOTAL_W-1:0] b;
    logic               cin;
    logic               busy;
    logic               done;
    logic [TOTAL_W-1:0] s;
    logic               cout;

    rca_seq_ctrl #(.SLICE_W(4), .NSLICE(NSLICE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .s      (s),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TOTAL_W-1:0] s;
        logic               cout;
        int                 done_cyc;
    } exp_t;

    exp_t sb_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt <= done_cnt + 1;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", {15'd0, cout, s}, {15'd0, e.cout, e.s});
                check("latency", cyc, e.done_cyc);
            end
        end
    end

    // Issue one request starting just after a rising edge while idle.
    task automatic launch(input logic [TOTAL_W-1:0] ta, input logic [TOTAL_W-1:0] tb_v,
                          input logic tcin, input logic tsub);
        exp_t        e;
        logic [16:0] r;
        if (tsub) r = {1'b0, ta} + {1'b0, ~tb_v} + 17'd1;
        else      r = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tcin};
        e.s        = r[15:0];
        e.cout     = r[16];
        e.done_cyc = cyc + 1 + NSLICE;
        sb_q.push_back(e);
        a = ta; b = tb_v; cin = tcin; op_sub = tsub; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        a      = 16'($urandom);
        b      = 16'($urandom);
        cin    = ~cin;
        op_sub = ~op_sub;
    endtask

    // Wait (bounded) for done, then step into the following idle cycle.
    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  b0;
        int  d0;
        bit  seen;

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s",    {16'd0, s},    32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: carry ripples through every slice.
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_done();

        // 2: add with carry-in; busy spans 4 RUN cycles plus DONE.
        b0 = busy_cnt;
        launch(16'h1234, 16'h4321, 1'b1, 1'b0); wait_done();
        check("busy_cycles", busy_cnt - b0, 32'd5);

        // 3: subtract ignores cin.
        launch(16'h0007, 16'h0005, 1'b0, 1'b1); wait_done();
        launch(16'h0007, 16'h0005, 1'b1, 1'b1); wait_done();
        launch(16'h0005, 16'h0007, 1'b0, 1'b1); wait_done();
        launch(16'h0005, 16'h0007, 1'b1, 1'b1); wait_done();

        // 4: start held high with changing operands while busy.
        d0 = done_cnt;
        launch(16'hA5A5, 16'h1111, 1'b0, 1'b0);
        start = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("ignored_starts_dones", done_cnt - d0, 32'd1);
        check("idle_after_ignored", {31'd0, busy}, 32'd0);

        // 5: asynchronous reset after two slices.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_s",    {16'd0, s},    32'd0);
        check("arst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        launch(16'h1111, 16'h2222, 1'b0, 1'b0); wait_done();

        // 6: random back-to-back operations.
        for (int i = 0; i < 2000; i++) begin
            launch(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait_done();
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
